// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - four-phase write/read-compare BIST initiator for a single-port memory
//
// Ports:
//   clk, res        clock, asynchronous active-high reset
//   start           one-cycle test request (honoured in IDLE or DONE only)
//   valid, wr_rd,   memory request side: strobe, 1=write/0=read,
//   addr, wdata     address and write data
//   rdata, ready    memory response side
//   busy, done,     status: test running, test finished (held),
//   pass            no mismatch and no timeout (valid with done)
//   err_cnt         saturating mismatch count
//   first_err_addr  address of first mismatch, 0 if none
//   timeout         test aborted because ready never arrived
module mem_bist_ctrl #(
  parameter int         WIDTH      = 8,
  parameter int         DEPTH      = 32,
  parameter int         ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  localparam int                    ERR_W      = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [7:0]            WAIT_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0]      SEED_W     = WIDTH'(SEED);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                state, state_n;
  logic [1:0]            ph, ph_n;
  logic [7:0]            wcnt, wcnt_n;
  logic                  valid_n, wr_rd_n, busy_n, done_n, pass_n, timeout_n;
  logic [ADDR_WIDTH-1:0] addr_n, ferr_n;
  logic [WIDTH-1:0]      wdata_n, expected;
  logic [ERR_W-1:0]      err_n;
  logic                  issue;

  function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return SEED_W ^ WIDTH'(a);
  endfunction

  always_comb begin
    state_n   = state;
    ph_n      = ph;
    wcnt_n    = wcnt;
    valid_n   = 1'b0;
    wr_rd_n   = wr_rd;
    addr_n    = addr;
    wdata_n   = wdata;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;
    err_n     = err_cnt;
    ferr_n    = first_err_addr;
    timeout_n = timeout;
    issue     = 1'b0;
    expected  = (ph == 2'd3) ? ~pattern(addr) : pattern(addr);

    case (state)
      S_IDLE, S_DONE: begin
        // done/pass are registered one cycle after DONE entry so they see the final err_cnt
        if (state == S_DONE) begin
          busy_n = 1'b0;
          done_n = 1'b1;
          pass_n = (err_cnt == '0) && !timeout;
        end
        if (start) begin
          err_n     = '0;
          ferr_n    = '0;
          timeout_n = 1'b0;
          done_n    = 1'b0;
          pass_n    = 1'b0;
          busy_n    = 1'b1;
          ph_n      = 2'd0;
          addr_n    = '0;
          issue     = 1'b1;
          state_n   = S_REQ;
        end
      end

      S_REQ: begin
        wcnt_n  = '0;
        state_n = S_WAIT;
      end

      S_WAIT: begin
        if (ready) begin
          if (ph[0] && (rdata != expected)) begin
            if (err_cnt != '1) err_n = err_cnt + ERR_W'(1);
            if (err_cnt == '0) ferr_n = addr;
          end
          if (addr == LAST_ADDR) begin
            addr_n = '0;
            if (ph == 2'd3) begin
              state_n = S_DONE;
            end else begin
              ph_n    = ph + 2'd1;
              issue   = 1'b1;
              state_n = S_REQ;
            end
          end else begin
            addr_n  = addr + ADDR_WIDTH'(1);
            issue   = 1'b1;
            state_n = S_REQ;
          end
        end else if (wcnt == WAIT_LIMIT) begin
          timeout_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Request outputs are registered, so they are loaded on the edge that enters REQ
    if (issue) begin
      valid_n = 1'b1;
      wr_rd_n = ~ph_n[0];
      case (ph_n)
        2'd0:    wdata_n = pattern(addr_n);
        2'd2:    wdata_n = ~pattern(addr_n);
        default: wdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state          <= S_IDLE;
      ph             <= 2'd0;
      wcnt           <= '0;
      valid          <= 1'b0;
      wr_rd          <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_n;
      ph             <= ph_n;
      wcnt           <= wcnt_n;
      valid          <= valid_n;
      wr_rd          <= wr_rd_n;
      addr           <= addr_n;
      wdata          <= wdata_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_cnt        <= err_n;
      first_err_addr <= ferr_n;
      timeout        <= timeout_n;
    end
  end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Built-in self-test initiator sitting directly upstream of the single-port memory block (`mem`).
- Drives the memory's request side (`valid`, `wr_rd`, `addr`, `wdata`) and consumes its response side (`rdata`, `ready`).
- On a start pulse it runs a four-phase write/read-compare sweep over every address, then reports pass/fail, error count, first failing address and timeout status.
- Used for power-on and debug checking of memory instances.

Parameters:
- WIDTH, 8: data width; must match the attached memory.
- DEPTH, 32: number of words to test; must match the attached memory.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- SEED, 8'hA5: base data pattern; truncated or zero-extended to WIDTH.
- TIMEOUT, 15: maximum cycles spent in a WAIT state before abort; must be 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE or DONE.
- valid  out  1  memory request strobe; high exactly one cycle per transaction.
- wr_rd  out  1  1 = write, 0 = read; meaningful only while valid=1.
- addr  out  ADDR_WIDTH  memory address.
- wdata  out  WIDTH  write data.
- rdata  in  WIDTH  read data from memory; valid when ready=1 after a read.
- ready  in  1  memory acknowledge.
- busy  out  1  test in progress.
- done  out  1  test finished; held until the next start or reset.
- pass  out  1  valid when done=1; 1 = no mismatch and no timeout.
- err_cnt  out  ADDR_WIDTH+2  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- timeout  out  1  set when the test aborted because ready never arrived.

Behaviour:
- Reset is asynchronous and active-high: asserting res forces IDLE immediately, including mid-test.
- Reset values: valid=0, wr_rd=0, addr=0, wdata=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, timeout=0.
- All outputs are registered.
- States: IDLE, REQ, WAIT, DONE. A phase register ph (0..3) and an address counter sit beside the FSM.
- Phases:
  - ph0: write P.
  - ph1: read and compare P.
  - ph2: write ~P.
  - ph3: read and compare ~P.
- Pattern: P(a) = SEED XOR a, with a zero-extended or truncated to WIDTH.
- IDLE or DONE with start=1:
  - clear err_cnt, first_err_addr, timeout, done, pass;
  - set ph=0, addr=0, busy=1;
  - go to REQ.
- REQ (one cycle):
  - valid=1, wr_rd=(ph even), wdata=P(addr) for ph0 or ~P(addr) for ph2, else 0;
  - next state WAIT; clear the wait counter.
- WAIT:
  - valid=0; addr and wr_rd are held.
  - If ready=1:
    - in ph1/ph3, compare rdata with the expected word;
    - on mismatch, increment err_cnt (saturating); if this is the first mismatch, capture addr into first_err_addr.
  - Then, if addr==DEPTH-1: addr=0 and ph++; after ph3, go to DONE. Otherwise addr++ and go to REQ.
  - If ready=0: increment the wait counter. When the counter reaches TIMEOUT, set timeout=1 and go to DONE.
- Throughput: one transaction per 2 cycles against a zero-wait memory.
- Nominal duration: start sampled at edge 0, first valid high after edge 0, done rises 8*DEPTH+1 edges after the start edge.
- DONE:
  - busy=0, done=1;
  - pass = (err_cnt==0) and !timeout.
- start while busy=1 is ignored.
- A ready=1 seen in REQ is ignored; only WAIT consumes ready.
- A stale ready high on WAIT entry (memory holds ready for one cycle after valid) counts as the acknowledge for the current request. This is the intended pairing with the attached memory.
- rdata is ignored during write phases and when ready=0.

Test Plan:
- Defaults, healthy memory model, start pulse:
  - 128 valid pulses: 64 writes, 64 reads;
  - first write addr=0, wdata=8'hA5; ph2 first wdata=8'h5A;
  - done after 257 edges; pass=1, err_cnt=0.
- Memory model forcing bit0 stuck-at-1 at addr 5:
  - ph1: P(5)=8'hA0, reads 8'hA1 → mismatch;
  - ph3: ~P(5)=8'h5F, reads 8'h5F → no mismatch;
  - result: err_cnt=1, first_err_addr=5, pass=0.
- Model never raises ready:
  - timeout=1 and done=1 after the 1st REQ cycle plus 15 WAIT cycles;
  - err_cnt=0, pass=0.
- res asserted asynchronously mid-ph1 (addr=10):
  - outputs go to reset values before the next edge;
  - a following start reruns from addr=0, ph0.
- start pulsed again while busy and again after done:
  - the first is ignored, with no restart or count change;
  - the second clears status and begins a new run.
- Memory injecting mismatches on every read in both phases:
  - err_cnt=64, first_err_addr=0, no saturation.
  - With ADDR_WIDTH+2 forced to 2 bits in a reduced-width build, err_cnt saturates at 3.
